// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: state encoding, well-known
// instruction words and the default reset PC.
package riscv_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] INSTR_EBREAK     = 32'h0010_0073;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register with next-pc selection: redirect target,
// hold, or sequential +4 (wrapping at 2^32).
module fetch_pc_gen
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_target,
  input  logic        i_advance,
  output logic [31:0] o_pc
);

  logic [31:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (i_load) begin
      r_pc <= i_target;
    end else if (i_advance) begin
      r_pc <= r_pc + 32'd4;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: drives the memory word address from the PC, captures
// returned words into the IF/ID register, and handles stall/redirect/halt.
module instruction_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W   = 11,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  input  logic              halt_req,
  output logic              if_id_valid,
  output logic [31:0]       if_id_instr,
  output logic [31:0]       if_id_pc,
  output logic              halted,
  output logic              misalign_err,
  output logic [31:0]       fetch_count
);

  fetch_state_t r_state;
  logic         r_valid;
  logic [31:0]  r_instr;
  logic [31:0]  r_ipc;
  logic         r_halted;
  logic         r_misalign;
  logic [31:0]  r_count;

  logic [31:0]  w_pc;
  logic         w_run;
  logic         w_target_ok;
  logic         w_load;
  logic         w_advance;

  assign w_run       = (r_state == RUN);
  assign w_target_ok = (redirect_pc[1:0] == 2'b00);
  assign w_load      = w_run && redirect && w_target_ok;
  // EBREAK still advances the PC: the word is consumed, then fetch stops.
  assign w_advance   = w_run && !redirect && !halt_req && !stall;

  fetch_pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_load),
    .i_target  (redirect_pc),
    .i_advance (w_advance),
    .o_pc      (w_pc)
  );

  assign imem_addr = w_pc[ADDR_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_valid    <= 1'b0;
      r_instr    <= INSTR_NOP;
      r_ipc      <= '0;
      r_halted   <= 1'b0;
      r_misalign <= 1'b0;
      r_count    <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (redirect) begin
            r_valid <= 1'b0;
            if (!w_target_ok) begin
              r_misalign <= 1'b1;
              r_halted   <= 1'b1;
              r_state    <= HALT;
            end
          end else if (halt_req) begin
            r_valid  <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= HALT;
          end else if (!stall) begin
            r_instr <= imem_rdata;
            r_ipc   <= w_pc;
            r_valid <= 1'b1;
            r_count <= r_count + 32'd1;
            if (imem_rdata == INSTR_EBREAK) begin
              r_halted <= 1'b1;
              r_state  <= HALT;
            end
          end
        end
        HALT: begin
          r_valid  <= 1'b0;
          r_halted <= 1'b1;
        end
        default: r_state <= HALT;
      endcase
    end
  end

  assign if_id_valid  = r_valid;
  assign if_id_instr  = r_instr;
  assign if_id_pc     = r_ipc;
  assign halted       = r_halted;
  assign misalign_err = r_misalign;
  assign fetch_count  = r_count;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a table of per-cycle vectors
// plus hand-written sequences for EBREAK, halt request, wrap and async reset.
module tb_instruction_fetch_unit;

  localparam int unsigned ADDR_W = 11;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBRK   = 32'h0010_0073;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_pc;
  logic              halt_req;
  logic              if_id_valid;
  logic [31:0]       if_id_instr;
  logic [31:0]       if_id_pc;
  logic              halted;
  logic              misalign_err;
  logic [31:0]       fetch_count;

  logic [31:0] mem [0:(1 << (ADDR_W - 2)) - 1];

  int n_vec;
  int n_err;

  instruction_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt_req     (halt_req),
    .if_id_valid  (if_id_valid),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .halted       (halted),
    .misalign_err (misalign_err),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign imem_rdata = mem[imem_addr[ADDR_W-1:2]];

  // Word stored at byte address a in the default memory image.
  function automatic logic [31:0] w(input logic [31:0] a);
    return 32'hC000_0000 | {21'd0, a[ADDR_W-1:0]};
  endfunction

  typedef struct {
    string       name;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        hreq;
    logic [10:0] addr;
    logic        valid;
    logic [31:0] ipc;
    logic [31:0] instr;
    logic [31:0] cnt;
    logic        halted;
    logic        mis;
  } vec_t;

  task automatic check(input string name, input logic [10:0] a, input logic v,
                       input logic [31:0] ipc, input logic [31:0] ins,
                       input logic [31:0] cnt, input logic h, input logic m);
    n_vec++;
    if (imem_addr !== a || if_id_valid !== v || if_id_pc !== ipc ||
        if_id_instr !== ins || fetch_count !== cnt || halted !== h ||
        misalign_err !== m) begin
      n_err++;
      $display("FAIL %s: got addr=%h valid=%b pc=%h instr=%h cnt=%0d halted=%b mis=%b; want addr=%h valid=%b pc=%h instr=%h cnt=%0d halted=%b mis=%b",
               name, imem_addr, if_id_valid, if_id_pc, if_id_instr, fetch_count,
               halted, misalign_err, a, v, ipc, ins, cnt, h, m);
    end
  endtask

  task automatic drive(input logic s, input logic r, input logic [31:0] rp,
                       input logic h);
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    halt_req    = h;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string name);
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check(name, 11'h000, 1'b0, 32'h0, NOP, 32'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  vec_t tbl [11];

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt_req = 1'b0;
    for (int unsigned i = 0; i < (1 << (ADDR_W - 2)); i++) mem[i] = w(i * 4);

    //            name         st   rd   rpc          hq   addr     v    ipc     instr      cnt  h    m
    tbl[0]  = '{"free0",      0, 0, 32'h0,       0, 11'h004, 1, 32'h00, w(32'h00), 1, 0, 0};
    tbl[1]  = '{"free1",      0, 0, 32'h0,       0, 11'h008, 1, 32'h04, w(32'h04), 2, 0, 0};
    tbl[2]  = '{"stall0",     1, 0, 32'h0,       0, 11'h008, 1, 32'h04, w(32'h04), 2, 0, 0};
    tbl[3]  = '{"stall1",     1, 0, 32'h0,       0, 11'h008, 1, 32'h04, w(32'h04), 2, 0, 0};
    tbl[4]  = '{"stall2",     1, 0, 32'h0,       0, 11'h008, 1, 32'h04, w(32'h04), 2, 0, 0};
    tbl[5]  = '{"release",    0, 0, 32'h0,       0, 11'h00C, 1, 32'h08, w(32'h08), 3, 0, 0};
    tbl[6]  = '{"redir_stall",1, 1, 32'h40,      0, 11'h040, 0, 32'h08, w(32'h08), 3, 0, 0};
    tbl[7]  = '{"after_redir",0, 0, 32'h0,       0, 11'h044, 1, 32'h40, w(32'h40), 4, 0, 0};
    tbl[8]  = '{"misalign",   0, 1, 32'h42,      0, 11'h044, 0, 32'h40, w(32'h40), 4, 1, 1};
    tbl[9]  = '{"halt_redir", 0, 1, 32'h0,       0, 11'h044, 0, 32'h40, w(32'h40), 4, 1, 1};
    tbl[10] = '{"halt_free",  0, 0, 32'h0,       1, 11'h044, 0, 32'h40, w(32'h40), 4, 1, 1};

    do_reset("reset_a");
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].stall, tbl[i].redir, tbl[i].rpc, tbl[i].hreq);
      check(tbl[i].name, tbl[i].addr, tbl[i].valid, tbl[i].ipc, tbl[i].instr,
            tbl[i].cnt, tbl[i].halted, tbl[i].mis);
    end

    // EBREAK at 0x0C: delivered with valid, then halted with pc frozen at 0x10.
    mem[3] = EBRK;
    do_reset("reset_b");
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0);
      check("ebrk_pre", 11'((i + 1) * 4), 1'b1, 32'(i * 4), w(32'(i * 4)),
            32'(i + 1), 1'b0, 1'b0);
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    check("ebrk_deliver", 11'h010, 1'b1, 32'h0C, EBRK, 32'd4, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    check("ebrk_frozen", 11'h010, 1'b0, 32'h0C, EBRK, 32'd4, 1'b1, 1'b0);
    mem[3] = w(32'h0C);

    // External halt request.
    do_reset("reset_c");
    drive(1'b0, 1'b0, '0, 1'b0);
    check("hreq_pre", 11'h004, 1'b1, 32'h0, w(32'h0), 32'd1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b1);
    check("hreq_halt", 11'h004, 1'b0, 32'h0, w(32'h0), 32'd1, 1'b1, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    check("hreq_frozen", 11'h004, 1'b0, 32'h0, w(32'h0), 32'd1, 1'b1, 1'b0);

    // Address wrap at 2^ADDR_W, then asynchronous reset mid-cycle.
    do_reset("reset_d");
    drive(1'b0, 1'b1, 32'h7FC, 1'b0);
    check("wrap_redir", 11'h7FC, 1'b0, 32'h0, NOP, 32'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    check("wrap_addr", 11'h000, 1'b1, 32'h7FC, w(32'h7FC), 32'd1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b0);
    check("wrap_alias", 11'h004, 1'b1, 32'h800, w(32'h000), 32'd2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", 11'h000, 1'b0, 32'h0, NOP, 32'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
